// File: rtl/pc_recovery_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_recovery_ctrl
// Description : Hold/redirect control source for the PC unit. Arbitrates
//               pipeline stalls, resolved branch redirects and fault-recovery
//               rollbacks to the instruction after the last commit. Halts the
//               core after MAX_RETRY rollbacks without forward progress.
// Ports       : clk, reset (async, active-low)
//               pc                 - current PC fed back from the PC unit
//               stall_req          - pipeline stall request
//               branch_taken/target- resolved taken branch and its target
//               commit_valid/pc    - retired instruction and its PC
//               fault_detect       - fault flagged on an in-flight instruction
//               pc_hold            - freeze PC (combinational)
//               pc_redirect/flush  - one-cycle redirect pulse and flush
//               redirect_addr      - redirect target (holds last value)
//               fault_halt         - sticky halt indication
//               retry_count        - rollbacks since the last commit
// Revision    : 1.0 - initial release
// ============================================================================
module pc_recovery_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic        fault_detect,
    output logic        pc_hold,
    output logic        pc_redirect,
    output logic [31:0] redirect_addr,
    output logic        flush,
    output logic        fault_halt,
    output logic [1:0]  retry_count
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_ROLLBACK = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [1:0] c_MAX_RETRY  = 2'(MAX_RETRY);

    state_t      r_state;
    logic [31:0] r_checkpoint;
    logic [3:0]  r_drain_cnt;
    // Verify flag and the address that the previous cycle's redirect loaded.
    // The address is captured separately so that a back-to-back redirect,
    // which already updates redirect_addr, does not corrupt the check.
    logic        r_verify;
    logic [31:0] r_verify_addr;

    logic w_branch_ok;
    logic w_misaligned;
    logic w_verify_fail;
    logic w_fault;

    assign w_branch_ok   = branch_taken & (branch_target[1:0] == 2'b00);
    assign w_misaligned  = branch_taken & (branch_target[1:0] != 2'b00);
    assign w_verify_fail = r_verify & (pc != r_verify_addr);
    assign w_fault       = fault_detect | w_misaligned | w_verify_fail;

    // A pending redirect always wins over a stall so the PC load is not lost.
    always_comb begin
        pc_hold = 1'b0;
        if (reset) begin
            case (r_state)
                ST_RUN:      pc_hold = stall_req & ~pc_redirect;
                ST_DRAIN:    pc_hold = 1'b1;
                ST_ROLLBACK: pc_hold = 1'b0;
                ST_HALT:     pc_hold = 1'b1;
                default:     pc_hold = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_checkpoint  <= RESET_VECTOR;
            r_drain_cnt   <= 4'd0;
            r_verify      <= 1'b0;
            r_verify_addr <= RESET_VECTOR;
            pc_redirect   <= 1'b0;
            flush         <= 1'b0;
            redirect_addr <= RESET_VECTOR;
            fault_halt    <= 1'b0;
            retry_count   <= 2'd0;
        end else begin
            r_verify      <= pc_redirect;
            r_verify_addr <= redirect_addr;
            pc_redirect   <= 1'b0;
            flush         <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (commit_valid) begin
                        r_checkpoint <= commit_pc + 32'd4;
                    end
                    if (w_fault) begin
                        if (retry_count == c_MAX_RETRY) begin
                            r_state    <= ST_HALT;
                            fault_halt <= 1'b1;
                        end else begin
                            // Increment wins over a same-cycle commit clear.
                            retry_count <= retry_count + 2'd1;
                            r_drain_cnt <= c_DRAIN_LOAD;
                            r_state     <= ST_DRAIN;
                        end
                    end else begin
                        if (commit_valid) begin
                            retry_count <= 2'd0;
                        end
                        if (w_branch_ok) begin
                            pc_redirect   <= 1'b1;
                            flush         <= 1'b1;
                            redirect_addr <= branch_target;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == 4'd0) begin
                        r_state       <= ST_ROLLBACK;
                        pc_redirect   <= 1'b1;
                        flush         <= 1'b1;
                        redirect_addr <= r_checkpoint;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 4'd1;
                    end
                end
                ST_ROLLBACK: begin
                    r_state <= ST_RUN;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
